// File: rtl/whizgraphics_lcd_timing_pkg.sv
// Shared video types for the whizgraphics LCD timing block.
// Contents:
//   ppu_mode_t        - PPU mode encoding as seen on the mode output
//   STAT_IE_*         - bit positions inside the stat_ie enable vector
//   DEF_*             - default scanline / frame timing
//   *_BLOCK_MASK      - per-resource mask of modes that lock the CPU out
package whizgraphics_lcd_timing_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } ppu_mode_t;

    localparam int STAT_IE_HBLANK = 0;
    localparam int STAT_IE_VBLANK = 1;
    localparam int STAT_IE_OAM    = 2;
    localparam int STAT_IE_LYC    = 3;

    localparam int DEF_DOTS_PER_LINE   = 456;
    localparam int DEF_LINES_PER_FRAME = 154;
    localparam int DEF_VISIBLE_LINES   = 144;
    localparam int DEF_OAM_DOTS        = 80;
    localparam int DEF_XFER_DOTS       = 172;

    // Bit n set = resource is owned by the renderer while mode == n.
    localparam logic [3:0] VRAM_BLOCK_MASK = 4'b1000;  // transfer only
    localparam logic [3:0] OAM_BLOCK_MASK  = 4'b1100;  // OAM scan + transfer

endpackage

// File: rtl/whizgraphics_access_arb.sv
// Single-resource CPU access arbiter (one instance each for VRAM and OAM).
// A held request is acked for one cycle, the cycle after the first edge at
// which the resource is not owned by the renderer.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset
//   active       - LCD enabled; when low nothing is blocked
//   mode         - current registered PPU mode
//   req          - CPU request, held until ack
//   ack          - one-cycle grant strobe
module whizgraphics_access_arb
    import whizgraphics_lcd_timing_pkg::*;
#(
    parameter logic [3:0] BLOCK_MASK = 4'b0000
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      active,
    input  ppu_mode_t mode,
    input  logic      req,
    output logic      ack
);

    logic blocked;
    logic ack_nxt;
    logic done;     // this request has already been granted

    assign blocked = active & BLOCK_MASK[mode];
    assign ack_nxt = req & ~blocked & ~done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack  <= 1'b0;
            done <= 1'b0;
        end else begin
            ack  <= ack_nxt;
            // stays set until the requester releases req
            done <= req & (done | ack_nxt);
        end
    end

endmodule

// File: rtl/whizgraphics_lcd_timing.sv
// Scanline/frame sequencer and VRAM/OAM access arbiter for the renderer.
// Counts dots and lines, drives the PPU mode, fires line_start and
// render_complete, raises VBlank and STAT interrupt strobes, and grants the
// CPU VRAM/OAM access when the renderer does not own them.
// Optional feature macro: WHIZ_MODE3_EXTEND_EN - pixel transfer is held
// while xfer_busy is high (past its nominal length), eating into HBlank.
// Ports:
//   clk, reset_n                  - dot clock, synchronous active-low reset
//   lcd_enable                    - LCDC bit 7
//   lyc, stat_ie                  - LY compare value, STAT source enables
//   cpu_vram_req/ack, cpu_oam_req/ack - CPU access handshake
//   xfer_busy                     - renderer still drawing (feature only)
//   mode, ly, lyc_match           - registered status
//   line_start, render_complete, vblank_irq, stat_irq - one-cycle pulses
module whizgraphics_lcd_timing
    import whizgraphics_lcd_timing_pkg::*;
#(
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
    parameter int OAM_DOTS        = DEF_OAM_DOTS,
    parameter int XFER_DOTS       = DEF_XFER_DOTS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    input  logic       cpu_vram_req,
    input  logic       cpu_oam_req,
    input  logic       xfer_busy,
    output logic       cpu_vram_ack,
    output logic       cpu_oam_ack,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic       lyc_match,
    output logic       line_start,
    output logic       render_complete,
    output logic       vblank_irq,
    output logic       stat_irq
);

    // Low two bits are the mode encoding; OFF reads as mode 0.
    localparam logic [2:0] S_HBLANK = 3'd0;
    localparam logic [2:0] S_VBLANK = 3'd1;
    localparam logic [2:0] S_OAM    = 3'd2;
    localparam logic [2:0] S_XFER   = 3'd3;
    localparam logic [2:0] S_OFF    = 3'd4;

    localparam logic [8:0] DOT_LAST   = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_XFER   = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_HBLANK = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_LAST    = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LY_VBLANK  = 8'(VISIBLE_LINES);

    logic [2:0] state, state_nxt;
    logic [8:0] dot, dot_nxt;
    logic [7:0] ly_nxt;
    logic       line_start_nxt;
    logic       frame_done_nxt;
    logic       lyc_match_nxt;
    logic       stat_line, stat_line_nxt;

`ifndef WHIZ_MODE3_EXTEND_EN
    logic xfer_busy_unused;
    assign xfer_busy_unused = xfer_busy;
`endif

    assign mode = state[1:0];

    always_comb begin
        state_nxt      = state;
        dot_nxt        = dot;
        ly_nxt         = ly;
        line_start_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        if (!lcd_enable) begin
            state_nxt = S_OFF;
            dot_nxt   = 9'd0;
            ly_nxt    = 8'd0;
        end else if (state == S_OFF) begin
            // first enabled cycle starts line 0 directly in OAM scan
            state_nxt      = S_OAM;
            dot_nxt        = 9'd0;
            ly_nxt         = 8'd0;
            line_start_nxt = 1'b1;
        end else if (dot == DOT_LAST) begin
            // line end wins over any extended transfer
            dot_nxt = 9'd0;
            ly_nxt  = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
            if (ly_nxt < LY_VBLANK) begin
                state_nxt      = S_OAM;
                line_start_nxt = 1'b1;
            end else begin
                state_nxt = S_VBLANK;
            end
            frame_done_nxt = (ly_nxt == LY_VBLANK);
        end else begin
            dot_nxt = dot + 9'd1;
            case (state)
                S_OAM:
                    if (dot_nxt == DOT_XFER) state_nxt = S_XFER;
                S_XFER:
                    if (dot_nxt >= DOT_HBLANK) begin
`ifdef WHIZ_MODE3_EXTEND_EN
                        if (!xfer_busy) state_nxt = S_HBLANK;
`else
                        state_nxt = S_HBLANK;
`endif
                    end
                default: ;
            endcase
        end
    end

    // Compare uses the current ly, so the match trails ly/lyc by one cycle.
    assign lyc_match_nxt = lcd_enable && (state != S_OFF) && (ly == lyc);

    // STAT line is built from next-cycle values so stat_line tracks the
    // registered outputs and stat_irq lands in the same cycle as its cause.
    always_comb begin
        stat_line_nxt = 1'b0;
        if (state_nxt != S_OFF)
            stat_line_nxt = (stat_ie[STAT_IE_HBLANK] && state_nxt == S_HBLANK) ||
                            (stat_ie[STAT_IE_VBLANK] && state_nxt == S_VBLANK) ||
                            (stat_ie[STAT_IE_OAM]    && state_nxt == S_OAM)    ||
                            (stat_ie[STAT_IE_LYC]    && lyc_match_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_OFF;
            dot             <= 9'd0;
            ly              <= 8'd0;
            line_start      <= 1'b0;
            render_complete <= 1'b0;
            vblank_irq      <= 1'b0;
            lyc_match       <= 1'b0;
            stat_line       <= 1'b0;
            stat_irq        <= 1'b0;
        end else begin
            state           <= state_nxt;
            dot             <= dot_nxt;
            ly              <= ly_nxt;
            line_start      <= line_start_nxt;
            render_complete <= frame_done_nxt;
            vblank_irq      <= frame_done_nxt;
            lyc_match       <= lyc_match_nxt;
            stat_line       <= stat_line_nxt;
            stat_irq        <= stat_line_nxt & ~stat_line;
        end
    end

    whizgraphics_access_arb #(.BLOCK_MASK(VRAM_BLOCK_MASK)) u_vram_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (lcd_enable),
        .mode    (ppu_mode_t'(state[1:0])),
        .req     (cpu_vram_req),
        .ack     (cpu_vram_ack)
    );

    whizgraphics_access_arb #(.BLOCK_MASK(OAM_BLOCK_MASK)) u_oam_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (lcd_enable),
        .mode    (ppu_mode_t'(state[1:0])),
        .req     (cpu_oam_req),
        .ack     (cpu_oam_ack)
    );

endmodule

// File: tb/tb_whizgraphics_lcd_timing.sv
// Directed bench for whizgraphics_lcd_timing: frame timing, arbitration,
// STAT edge detection, LCD disable, mid-line reset and (when the macro
// WHIZ_MODE3_EXTEND_EN is defined) transfer extension.
module tb_whizgraphics_lcd_timing;

    logic       clk;
    logic       reset_n;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       cpu_vram_req;
    logic       cpu_oam_req;
    logic       xfer_busy;
    logic       cpu_vram_ack;
    logic       cpu_oam_ack;
    logic [1:0] mode;
    logic [7:0] ly;
    logic       lyc_match;
    logic       line_start;
    logic       render_complete;
    logic       vblank_irq;
    logic       stat_irq;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    whizgraphics_lcd_timing dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .lcd_enable      (lcd_enable),
        .lyc             (lyc),
        .stat_ie         (stat_ie),
        .cpu_vram_req    (cpu_vram_req),
        .cpu_oam_req     (cpu_oam_req),
        .xfer_busy       (xfer_busy),
        .cpu_vram_ack    (cpu_vram_ack),
        .cpu_oam_ack     (cpu_oam_ack),
        .mode            (mode),
        .ly              (ly),
        .lyc_match       (lyc_match),
        .line_start      (line_start),
        .render_complete (render_complete),
        .vblank_irq      (vblank_irq),
        .stat_irq        (stat_irq)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_mode(input int l, input int d);
        if (l >= 144) return 1;
        if (d < 80)   return 2;
        if (d < 252)  return 3;
        return 0;
    endfunction

    // mode for dot d of a line where xfer_busy is high through dot 299;
    // d == 456 is dot 0 of the following line
    function automatic int exp_busy_mode(input int d);
        if (d == 456) return 2;
        if (d < 80)   return 2;
`ifdef WHIZ_MODE3_EXTEND_EN
        if (d <= 300) return 3;
`else
        if (d < 252)  return 3;
`endif
        return 0;
    endfunction

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mode"},       int'(mode), 0);
        chk({pfx, "_ly"},         int'(ly), 0);
        chk({pfx, "_line_start"}, int'(line_start), 0);
        chk({pfx, "_rc"},         int'(render_complete), 0);
        chk({pfx, "_vblank"},     int'(vblank_irq), 0);
        chk({pfx, "_stat"},       int'(stat_irq), 0);
        chk({pfx, "_lyc_match"},  int'(lyc_match), 0);
        chk({pfx, "_vram_ack"},   int'(cpu_vram_ack), 0);
        chk({pfx, "_oam_ack"},    int'(cpu_oam_ack), 0);
    endtask

    initial begin
        int ed, el, bad, bad_mode, bad_ly, bad_ls, bad_vb;
        int rc_cnt, rc_at, st_cnt, st_at, va_cnt, va_at, oa_cnt, oa_at;
        n_cmp = 0; n_err = 0;
        bad = 0; bad_mode = 0; bad_ly = 0; bad_ls = 0; bad_vb = 0;
        rc_cnt = 0; rc_at = -1; st_cnt = 0; st_at = -1;
        va_cnt = 0; va_at = -10; oa_cnt = 0; oa_at = -10;

        reset_n = 1'b0; lcd_enable = 1'b0; lyc = 8'd10; stat_ie = 4'b1000;
        cpu_vram_req = 1'b0; cpu_oam_req = 1'b0; xfer_busy = 1'b0;
        tick(); tick();
        chk_reset_outputs("reset");

        // LCD off: requests pass straight through, one ack each
        reset_n = 1'b1;
        tick();
        cpu_vram_req = 1'b1; cpu_oam_req = 1'b1;
        tick();
        chk("off_vram_ack", int'(cpu_vram_ack), 1);
        chk("off_oam_ack",  int'(cpu_oam_ack), 1);
        tick();
        chk("off_vram_single", int'(cpu_vram_ack), 0);
        chk("off_oam_single",  int'(cpu_oam_ack), 0);
        cpu_vram_req = 1'b0; cpu_oam_req = 1'b0;

        // Full frame, cycle c = dot index since enable
        lcd_enable = 1'b1;
        for (int c = 0; c <= 70224; c++) begin
            tick();
            ed = c % 456;
            el = (c / 456) % 154;
            if (int'(mode) != exp_mode(el, ed)) bad_mode++;
            if (int'(ly) != el) bad_ly++;
            if (line_start != ((ed == 0) && (el < 144))) bad_ls++;
            if (vblank_irq != render_complete) bad_vb++;
            if (render_complete) begin rc_cnt++; rc_at = c; end
            if (stat_irq && c < 70224) begin st_cnt++; st_at = c; end
            if (cpu_vram_ack) begin va_cnt++; va_at = c; end
            if (cpu_oam_ack)  begin oa_cnt++; oa_at = c; end
            if (c == 0)   chk("a_c0_line_start", int'(line_start), 1);
            if (c == 79)  chk("a_dot79_mode",  int'(mode), 2);
            if (c == 80)  chk("a_dot80_mode",  int'(mode), 3);
            if (c == 251) chk("a_dot251_mode", int'(mode), 3);
            if (c == 252) chk("a_dot252_mode", int'(mode), 0);
            if (c == 455) chk("a_dot455_mode", int'(mode), 0);
            if (c == 153 * 456) chk("a_ly153", int'(ly), 153);
            if (c == 153 * 456) chk("a_ly153_mode", int'(mode), 1);
            if (c == 70224) chk("a_wrap_ly", int'(ly), 0);
            if (c == 70224) chk("a_wrap_mode", int'(mode), 2);
            if (c == 5 * 456 + 10)  cpu_oam_req  = 1'b1;
            if (c == 5 * 456 + 100) cpu_vram_req = 1'b1;
            // hold req through the ack cycle, release one cycle later
            if (c == va_at + 1) cpu_vram_req = 1'b0;
            if (c == oa_at + 1) cpu_oam_req  = 1'b0;
        end
        chk("a_mode_scan_errs", bad_mode, 0);
        chk("a_ly_scan_errs",   bad_ly, 0);
        chk("a_ls_scan_errs",   bad_ls, 0);
        chk("a_vblank_vs_rc",   bad_vb, 0);
        chk("a_rc_count",       rc_cnt, 1);
        chk("a_rc_cycle",       rc_at, 144 * 456);
        chk("a_stat_count",     st_cnt, 1);
        chk("a_stat_cycle",     st_at, 10 * 456 + 1);
        chk("a_vram_ack_count", va_cnt, 1);
        chk("a_vram_ack_cycle", va_at, 5 * 456 + 253);
        chk("a_oam_ack_count",  oa_cnt, 1);
        chk("a_oam_ack_cycle",  oa_at, 5 * 456 + 253);

        // Second frame: LYC + HBlank enabled, only one pulse on line 10
        stat_ie = 4'b1001;
        st_cnt = 0; st_at = -1;
        for (int b = 1; b <= 11 * 456 + 200; b++) begin
            tick();
            ed = b % 456;
            el = b / 456;
            if (stat_irq && el == 10) begin st_cnt++; st_at = ed; end
            if (b == 10 * 456)     chk("b_ly10_dot0_lycm", int'(lyc_match), 0);
            if (b == 10 * 456 + 1) chk("b_ly10_dot1_lycm", int'(lyc_match), 1);
            if (b == 11 * 456 + 150) cpu_oam_req = 1'b1;
        end
        chk("b_ly10_stat_pulses", st_cnt, 1);
        chk("b_ly10_stat_dot",    st_at, 1);
        chk("drop_pre_mode", int'(mode), 3);
        chk("drop_pre_ly",   int'(ly), 11);

        // Disable mid-frame with an OAM request pending
        lcd_enable = 1'b0;
        tick();
        chk("drop_mode",       int'(mode), 0);
        chk("drop_ly",         int'(ly), 0);
        chk("drop_rc",         int'(render_complete), 0);
        chk("drop_line_start", int'(line_start), 0);
        chk("drop_oam_ack",    int'(cpu_oam_ack), 1);
        tick();
        chk("drop_oam_single", int'(cpu_oam_ack), 0);
        cpu_oam_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (render_complete || line_start || vblank_irq || stat_irq) bad++;
        end
        chk("off_no_pulses", bad, 0);

        lyc = 8'd0;
        lcd_enable = 1'b1;
        tick();
        chk("reen_line_start", int'(line_start), 1);
        chk("reen_mode",       int'(mode), 2);
        chk("reen_ly",         int'(ly), 0);

        // Reset for one cycle in the middle of pixel transfer
        for (int d = 1; d <= 100; d++) begin
            tick();
            if (d == 90) cpu_vram_req = 1'b1;
        end
        chk("pre_rst_mode", int'(mode), 3);
        chk("pre_rst_lycm", int'(lyc_match), 1);
        reset_n = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        reset_n = 1'b1;
        cpu_vram_req = 1'b0;
        tick();
        chk("post_rst_line_start", int'(line_start), 1);
        chk("post_rst_mode",       int'(mode), 2);
        chk("post_rst_vram_ack",   int'(cpu_vram_ack), 0);

        // Line with xfer_busy high through dot 299
        bad = 0;
        xfer_busy = 1'b1;
        for (int d = 1; d <= 456; d++) begin
            tick();
            if (int'(mode) != exp_busy_mode(d)) bad++;
            if (d == 300) chk("busy_dot300_mode", int'(mode), exp_busy_mode(300));
            if (d == 301) chk("busy_dot301_mode", int'(mode), 0);
            if (d == 455) chk("busy_dot455_ly",   int'(ly), 0);
            if (d == 456) chk("busy_next_ly",     int'(ly), 1);
            if (d == 456) chk("busy_next_ls",     int'(line_start), 1);
            xfer_busy = (d < 300);
        end
        xfer_busy = 1'b0;
        chk("busy_mode_scan_errs", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
